instr_aligner: RTL and testbench

Fetch-side producer for the instruction decoder. It issues word-aligned 32-bit fetches and buffers the returned halfwords. It then presents one complete instruction per handshake, either a 16-bit compressed or a 32-bit normal instruction, with its PC and an is_compact flag. It also handles branch/jump redirects, including redirects to halfword-aligned targets.

---
 rtl/instr_aligner.sv | 145 ++++++++++++++
 tb/tb_instr_aligner.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_aligner.sv
`default_nettype none
// ============================================================================
// instr_aligner: word-aligned fetcher and halfword realigner feeding the decoder
// Revision: 1.0
// ============================================================================
module instr_aligner #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_valid,
  input  logic [31:0]           mem_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [31:0]           instruction,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  is_compact,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc
);

  logic [63:0]           buf_q, buf_d;
  logic [2:0]            count_q, count_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
  logic                  outstanding_q, outstanding_d;
  logic                  drop_resp_q, drop_resp_d;
  logic                  skip_low_q, skip_low_d;

  logic                  w_head_compact;
  logic                  w_fire;
  logic                  w_accept;
  logic                  w_issue;
  logic [2:0]            w_consumed;
  logic [2:0]            w_remaining;
  logic [2:0]            w_appended;
  logic [31:0]           w_append_data;
  logic [63:0]           w_shifted;
  logic [63:0]           w_append_bits;

  assign w_head_compact = (buf_q[1:0] != 2'b11);
  assign is_compact     = (count_q != 3'd0) && w_head_compact;
  assign instr_valid    = is_compact || (count_q >= 3'd2);
  assign instruction    = !instr_valid    ? 32'h0 :
                          w_head_compact  ? {16'h0, buf_q[15:0]} : buf_q[31:0];
  assign instr_pc       = pc_q;

  assign w_issue  = !outstanding_q && (count_q <= 3'd2) && !redirect_valid && !reset;
  assign mem_req  = w_issue;
  assign mem_addr = fetch_addr_q;

  assign w_fire      = instr_valid && instr_ready;
  assign w_consumed  = !w_fire ? 3'd0 : (w_head_compact ? 3'd1 : 3'd2);
  assign w_remaining = count_q - w_consumed;

  assign w_accept      = mem_valid && !drop_resp_q;
  assign w_append_data = !w_accept  ? 32'h0 :
                         skip_low_q ? {16'h0, mem_rdata[31:16]} : mem_rdata;
  assign w_appended    = !w_accept ? 3'd0 : (skip_low_q ? 3'd1 : 3'd2);

  always_comb begin
    w_shifted = buf_q;
    case (w_consumed)
      3'd1:    w_shifted = {16'h0, buf_q[63:16]};
      3'd2:    w_shifted = {32'h0, buf_q[63:32]};
      default: w_shifted = buf_q;
    endcase
  end

  // New halfwords land directly behind whatever survives this cycle's consume.
  always_comb begin
    w_append_bits = 64'h0;
    case (w_remaining)
      3'd0:    w_append_bits = {32'h0, w_append_data};
      3'd1:    w_append_bits = {16'h0, w_append_data, 16'h0};
      3'd2:    w_append_bits = {w_append_data, 32'h0};
      3'd3:    w_append_bits = {w_append_data[15:0], 48'h0};
      default: w_append_bits = 64'h0;
    endcase
  end

  always_comb begin
    buf_d         = buf_q;
    count_d       = count_q;
    pc_d          = pc_q;
    fetch_addr_d  = fetch_addr_q;
    outstanding_d = outstanding_q;
    drop_resp_d   = drop_resp_q;
    skip_low_d    = skip_low_q;

    if (redirect_valid) begin
      buf_d         = 64'h0;
      count_d       = 3'd0;
      pc_d          = redirect_pc & ~ADDR_WIDTH'(1);
      fetch_addr_d  = redirect_pc & ~ADDR_WIDTH'(3);
      skip_low_d    = redirect_pc[1];
      // An in-flight request keeps the slot busy until its stale data shows up.
      outstanding_d = outstanding_q && !mem_valid;
      drop_resp_d   = outstanding_q && !mem_valid;
    end else begin
      buf_d   = w_shifted | w_append_bits;
      count_d = w_remaining + w_appended;
      pc_d    = pc_q + ADDR_WIDTH'({w_consumed, 1'b0});

      if (mem_valid) begin
        outstanding_d = 1'b0;
        if (drop_resp_q) begin
          drop_resp_d = 1'b0;
        end else if (skip_low_q) begin
          skip_low_d = 1'b0;
        end
      end

      if (w_issue) begin
        outstanding_d = 1'b1;
        fetch_addr_d  = fetch_addr_q + ADDR_WIDTH'(4);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q         <= 64'h0;
      count_q       <= 3'd0;
      pc_q          <= RESET_PC;
      fetch_addr_q  <= RESET_PC & ~ADDR_WIDTH'(3);
      outstanding_q <= 1'b0;
      drop_resp_q   <= 1'b0;
      skip_low_q    <= RESET_PC[1];
    end else begin
      buf_q         <= buf_d;
      count_q       <= count_d;
      pc_q          <= pc_d;
      fetch_addr_q  <= fetch_addr_d;
      outstanding_q <= outstanding_d;
      drop_resp_q   <= drop_resp_d;
      skip_low_q    <= skip_low_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_aligner.sv
`default_nettype none
// ============================================================================
// tb_instr_aligner: scoreboard bench for the fetch-side instruction aligner
// Revision: 1.0
// ============================================================================
module tb_instr_aligner;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        is_compact;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        compact;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] req_log[$];
  logic [31:0] mem_map [logic [31:0]];
  logic [31:0] mem_default = 32'h0000_0013;
  int          lat = 2;
  int          n_vec = 0;
  int          n_err = 0;

  instr_aligner #(.ADDR_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .reset         (reset),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_valid     (mem_valid),
    .mem_rdata     (mem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instruction   (instruction),
    .instr_pc      (instr_pc),
    .is_compact    (is_compact),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_map.exists(a)) return mem_map[a];
    return mem_default;
  endfunction

  function automatic logic [31:0] log_at(input int i);
    if (i < req_log.size()) return req_log[i];
    return 32'hFFFF_FFFF;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_instr(input logic [31:0] i, input logic [31:0] p, input logic c);
    exp_t e;
    e.instr   = i;
    e.pc      = p;
    e.compact = c;
    exp_q.push_back(e);
  endtask

  // Memory: one response per request, lat cycles after the request cycle.
  task automatic mem_model();
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = 32'h0;
    logic        req_s, rst_s;
    logic [31:0] addr_s;
    forever begin
      @(negedge clk);
      req_s  = mem_req;
      addr_s = mem_addr;
      rst_s  = reset;
      @(posedge clk);
      #1;
      mem_valid = 1'b0;
      mem_rdata = 32'h0;
      if (rst_s) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          cnt = cnt - 1;
          if (cnt <= 0) begin
            mem_valid = 1'b1;
            mem_rdata = mem_word(paddr);
            pend = 1'b0;
          end
        end
        if (req_s) begin
          n_vec++;
          if (pend) begin
            n_err++;
            $display("FAIL overlap_req: request %h issued while %h still in flight", addr_s, paddr);
          end
          req_log.push_back(addr_s);
          pend  = 1'b1;
          paddr = addr_s;
          cnt   = lat - 1;
          if (cnt <= 0) begin
            mem_valid = 1'b1;
            mem_rdata = mem_word(paddr);
            pend = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && !redirect_valid && instr_valid && instr_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_instr: got %h pc %h compact %b, required none", instruction, instr_pc, is_compact);
        end else begin
          e = exp_q.pop_front();
          if (instruction !== e.instr || instr_pc !== e.pc || is_compact !== e.compact) begin
            n_err++;
            $display("FAIL instr_stream: got %h pc %h compact %b, required %h pc %h compact %b",
                     instruction, instr_pc, is_compact, e.instr, e.pc, e.compact);
          end
        end
      end
    end
  endtask

  task automatic apply_reset();
    reset          = 1'b1;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    step();
    step();
    mem_map.delete();
    req_log.delete();
    exp_q.delete();
  endtask

  task automatic drain(input int max_cyc, input string name);
    instr_ready = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (exp_q.size() == 0) break;
    end
    instr_ready = 1'b0;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: %0d instructions still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    n_vec++;
    if (mem_req !== 1'b0 || instr_valid !== 1'b0 || is_compact !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: req %b valid %b compact %b, required 0 0 0", mem_req, instr_valid, is_compact);
    end
    n_vec++;
    if (instruction !== 32'h0 || instr_pc !== 32'h0 || mem_addr !== 32'h0) begin
      n_err++;
      $display("FAIL reset_data: instr %h pc %h addr %h, required 0 0 0", instruction, instr_pc, mem_addr);
    end
    step();
  endtask

  task automatic test_straight();
    apply_reset();
    lat = 2;
    mem_default = 32'h0000_0013;
    mem_map[32'h0] = 32'h00A0_0093;
    mem_map[32'h4] = 32'h0010_0113;
    expect_instr(32'h00A0_0093, 32'h0, 1'b0);
    expect_instr(32'h0010_0113, 32'h4, 1'b0);
    reset = 1'b0;
    drain(40, "straight");
    repeat (3) step();
    @(negedge clk);
    n_vec++;
    if (log_at(0) !== 32'h0 || log_at(1) !== 32'h4 || log_at(2) !== 32'h8) begin
      n_err++;
      $display("FAIL straight_addr: got %h %h %h, required 0 4 8", log_at(0), log_at(1), log_at(2));
    end
    step();
  endtask

  task automatic test_mixed();
    apply_reset();
    lat = 2;
    mem_default = 32'h0000_0013;
    mem_map[32'h0] = 32'h0093_4505;
    mem_map[32'h4] = 32'h0000_00A0;
    expect_instr(32'h0000_4505, 32'h0, 1'b1);
    expect_instr(32'h00A0_0093, 32'h2, 1'b0);
    expect_instr(32'h0000_0000, 32'h6, 1'b1);
    reset = 1'b0;
    drain(60, "mixed");
  endtask

  task automatic test_backpressure();
    int   unstable = 0;
    bit   seen = 1'b0;
    logic req_now = 1'b0;
    int   nreq = 0;
    apply_reset();
    lat = 1;
    mem_default = 32'h4505_4505;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (instr_valid) begin
        seen = 1'b1;
        if (instruction !== 32'h0000_4505 || instr_pc !== 32'h0 || is_compact !== 1'b1) unstable++;
      end
      if (i == 5) begin
        req_now = mem_req;
        nreq    = req_log.size();
      end
      step();
    end
    n_vec++;
    if (!seen || unstable != 0) begin
      n_err++;
      $display("FAIL stall_hold: seen %b unstable %0d, required 1 0", seen, unstable);
    end
    n_vec++;
    if (nreq != 2 || req_now !== 1'b0) begin
      n_err++;
      $display("FAIL stall_fetch: requests %0d req %b, required 2 0", nreq, req_now);
    end
    for (int k = 0; k < 8; k++) expect_instr(32'h0000_4505, 32'(2 * k), 1'b1);
    drain(60, "backpressure");
  endtask

  task automatic test_redirect_outstanding();
    bit found = 1'b0;
    apply_reset();
    lat = 3;
    mem_default = 32'h0000_0013;
    mem_map[32'h0]   = 32'h00A0_0093;
    mem_map[32'h4]   = 32'h0010_0113;
    mem_map[32'h8]   = 32'hDEAD_BEEF;
    mem_map[32'h104] = 32'h4505_FFFF;
    expect_instr(32'h00A0_0093, 32'h0, 1'b0);
    expect_instr(32'h0010_0113, 32'h4, 1'b0);
    expect_instr(32'h0000_4505, 32'h106, 1'b1);
    reset = 1'b0;
    instr_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 32'h8) begin
        found = 1'b1;
        break;
      end
      step();
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL redir_wait: fetch of 8 seen %b, required 1", found);
    end
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h106;
    step();
    redirect_valid = 1'b0;
    drain(60, "redir_outstanding");
    @(negedge clk);
    n_vec++;
    if (log_at(2) !== 32'h8 || log_at(3) !== 32'h104) begin
      n_err++;
      $display("FAIL redir_addr: got %h %h, required 8 104", log_at(2), log_at(3));
    end
    step();
  endtask

  task automatic test_redirect_collide();
    bit found = 1'b0;
    apply_reset();
    lat = 1;
    mem_default = 32'h0000_0013;
    mem_map[32'h0]   = 32'h4505_4505;
    mem_map[32'h4]   = 32'h4505_4505;
    mem_map[32'h200] = 32'h0093_FFFF;
    mem_map[32'h204] = 32'h0000_00A0;
    expect_instr(32'h0000_4505, 32'h0, 1'b1);
    expect_instr(32'h00A0_0093, 32'h202, 1'b0);
    expect_instr(32'h0000_0000, 32'h206, 1'b1);
    reset = 1'b0;
    instr_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 32'h4) begin
        found = 1'b1;
        break;
      end
      step();
    end
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h202;
    @(negedge clk);
    n_vec++;
    if (!found || mem_valid !== 1'b1 || instr_valid !== 1'b1 || instr_ready !== 1'b1) begin
      n_err++;
      $display("FAIL collide_setup: found %b mem_valid %b instr_valid %b, required 1 1 1", found, mem_valid, instr_valid);
    end
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h200 || instr_valid !== 1'b0 || instr_pc !== 32'h202) begin
      n_err++;
      $display("FAIL collide_after: req %b addr %h valid %b pc %h, required 1 200 0 202",
               mem_req, mem_addr, instr_valid, instr_pc);
    end
    step();
    drain(60, "redir_collide");
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    lat = 1;
    mem_default = 32'h4505_4505;
    expect_instr(32'h0000_4505, 32'h0, 1'b1);
    reset = 1'b0;
    repeat (6) step();
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h2 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL midstream_pre: valid %b pc %h pending %0d, required 1 2 0", instr_valid, instr_pc, exp_q.size());
    end
    step();
    @(negedge clk);
    n_vec++;
    if (instr_valid !== 1'b0 || mem_req !== 1'b0 || instruction !== 32'h0 || is_compact !== 1'b0) begin
      n_err++;
      $display("FAIL midstream_reset: valid %b req %b instr %h compact %b, required 0 0 0 0",
               instr_valid, mem_req, instruction, is_compact);
    end
    step();
    req_log.delete();
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h0 || instr_pc !== 32'h0) begin
      n_err++;
      $display("FAIL midstream_restart: req %b addr %h pc %h, required 1 0 0", mem_req, mem_addr, instr_pc);
    end
    step();
  endtask

  initial begin
    reset          = 1'b1;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    mem_valid      = 1'b0;
    mem_rdata      = 32'h0;
    fork
      mem_model();
      monitor();
    join_none
    step();
    test_reset();
    test_straight();
    test_mixed();
    test_backpressure();
    test_redirect_outstanding();
    test_redirect_collide();
    test_reset_midstream();
    apply_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
